mu0_control: RTL and testbench

- MU0 control unit: a two-phase fetch/execute FSM.
- Decodes the opcode field F (IR[15:12]) and the accumulator flags N and Z.
- Drives the datapath select lines, including Addr_sel into the address mu0_mux16 S input and X_sel/Y_sel into the ALU-operand mu0_mux16 instances.
- Also drives the register enables and the memory strobes. Sits directly upstream of the datapath multiplexers.

---
 rtl/mu0_control_if.sv | 32 +++
 rtl/mu0_control.sv | 120 ++++++++++++
 tb/tb_mu0_control.sv | 243 ++++++++++++++++++++++++
 3 files changed

// File: rtl/mu0_control_if.sv
// rtl/mu0_control_if.sv - MU0 control unit decode inputs and datapath control outputs
interface mu0_control_if #(
    parameter int CNT_W = 16
);
    logic [3:0]       F;
    logic             N;
    logic             Z;
    logic             Addr_sel;
    logic             X_sel;
    logic             Y_sel;
    logic [1:0]       ALU_FS;
    logic             PC_En;
    logic             IR_En;
    logic             Acc_En;
    logic             Rd;
    logic             Wr;
    logic             Halted;
    logic             Fetch;
    logic [CNT_W-1:0] Inst_Count;

    modport master (
        input  F, N, Z,
        output Addr_sel, X_sel, Y_sel, ALU_FS, PC_En, IR_En, Acc_En,
        output Rd, Wr, Halted, Fetch, Inst_Count
    );

    modport slave (
        output F, N, Z,
        input  Addr_sel, X_sel, Y_sel, ALU_FS, PC_En, IR_En, Acc_En,
        input  Rd, Wr, Halted, Fetch, Inst_Count
    );
endinterface

// File: rtl/mu0_control.sv
// rtl/mu0_control.sv - MU0 fetch/execute control FSM with instruction counter
module mu0_control #(
    parameter bit HALT_ON_ILLEGAL = 1'b0,
    parameter int CNT_W           = 16
) (
    input  logic           Clk,
    input  logic           nReset,
    mu0_control_if.master  bus
);
    localparam logic [1:0] S_FETCH = 2'd0;
    localparam logic [1:0] S_EXEC  = 2'd1;
    localparam logic [1:0] S_HALT  = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             stop;

    logic       addr_sel, x_sel, y_sel, pc_en, ir_en, acc_en, rd, wr, halted, fetch;
    logic [1:0] alu_fs;

    assign stop = (bus.F == 4'd7) || (bus.F[3] && HALT_ON_ILLEGAL);

    always_comb begin
        state_d = S_FETCH;
        case (state_q)
            S_FETCH: state_d = S_EXEC;
            S_EXEC:  state_d = stop ? S_HALT : S_FETCH;
            S_HALT:  state_d = S_HALT;
            default: state_d = S_FETCH;
        endcase
    end

    assign cnt_d = (state_q == S_EXEC) ? cnt_q + CNT_W'(1) : cnt_q;

    always_ff @(posedge Clk or negedge nReset) begin
        if (!nReset) begin
            state_q <= S_FETCH;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Outputs are gated by nReset so a write in flight drops the instant reset asserts.
    always_comb begin
        addr_sel = 1'b0;
        x_sel    = 1'b0;
        y_sel    = 1'b0;
        alu_fs   = 2'b00;
        pc_en    = 1'b0;
        ir_en    = 1'b0;
        acc_en   = 1'b0;
        rd       = 1'b0;
        wr       = 1'b0;
        halted   = 1'b0;
        fetch    = 1'b0;
        if (!nReset) begin
            fetch = 1'b1;
        end else begin
            case (state_q)
                S_FETCH: begin
                    fetch  = 1'b1;
                    rd     = 1'b1;
                    ir_en  = 1'b1;
                    x_sel  = 1'b1;
                    alu_fs = 2'b10;
                    pc_en  = 1'b1;
                end
                S_EXEC: begin
                    case (bus.F)
                        4'd0: begin
                            addr_sel = 1'b1;
                            rd       = 1'b1;
                            acc_en   = 1'b1;
                        end
                        4'd1: begin
                            addr_sel = 1'b1;
                            wr       = 1'b1;
                        end
                        4'd2, 4'd3: begin
                            addr_sel = 1'b1;
                            rd       = 1'b1;
                            acc_en   = 1'b1;
                            alu_fs   = (bus.F == 4'd2) ? 2'b01 : 2'b11;
                        end
                        4'd4: begin
                            y_sel = 1'b1;
                            pc_en = 1'b1;
                        end
                        4'd5: begin
                            y_sel = 1'b1;
                            pc_en = !bus.N;
                        end
                        4'd6: begin
                            y_sel = 1'b1;
                            pc_en = !bus.Z;
                        end
                        default: ;
                    endcase
                end
                S_HALT:  halted = 1'b1;
                default: ;
            endcase
        end
    end

    assign bus.Addr_sel   = addr_sel;
    assign bus.X_sel      = x_sel;
    assign bus.Y_sel      = y_sel;
    assign bus.ALU_FS     = alu_fs;
    assign bus.PC_En      = pc_en;
    assign bus.IR_En      = ir_en;
    assign bus.Acc_En     = acc_en;
    assign bus.Rd         = rd;
    assign bus.Wr         = wr;
    assign bus.Halted     = halted;
    assign bus.Fetch      = fetch;
    assign bus.Inst_Count = cnt_q;
endmodule

// File: tb/tb_mu0_control.sv
// tb/tb_mu0_control.sv - self-checking bench for mu0_control
module tb_mu0_control;
    logic       Clk;
    logic       nReset;
    logic [3:0] f_r;
    logic       n_r;
    logic       z_r;

    mu0_control_if #(.CNT_W(16)) b0 ();
    mu0_control_if #(.CNT_W(16)) b1 ();
    mu0_control_if #(.CNT_W(4))  b2 ();

    mu0_control #(.HALT_ON_ILLEGAL(1'b0), .CNT_W(16)) dut0 (.Clk(Clk), .nReset(nReset), .bus(b0));
    mu0_control #(.HALT_ON_ILLEGAL(1'b1), .CNT_W(16)) dut1 (.Clk(Clk), .nReset(nReset), .bus(b1));
    mu0_control #(.HALT_ON_ILLEGAL(1'b0), .CNT_W(4))  dut2 (.Clk(Clk), .nReset(nReset), .bus(b2));

    assign b0.F = f_r;
    assign b0.N = n_r;
    assign b0.Z = z_r;
    assign b1.F = f_r;
    assign b1.N = n_r;
    assign b1.Z = z_r;
    assign b2.F = f_r;
    assign b2.N = n_r;
    assign b2.Z = z_r;

    // Packed as {Addr_sel, X_sel, Y_sel, ALU_FS, PC_En, IR_En, Acc_En, Rd, Wr, Halted, Fetch}
    logic [11:0] outv [3];
    logic [15:0] cntv [3];
    assign outv[0] = {b0.Addr_sel, b0.X_sel, b0.Y_sel, b0.ALU_FS, b0.PC_En, b0.IR_En,
                      b0.Acc_En, b0.Rd, b0.Wr, b0.Halted, b0.Fetch};
    assign outv[1] = {b1.Addr_sel, b1.X_sel, b1.Y_sel, b1.ALU_FS, b1.PC_En, b1.IR_En,
                      b1.Acc_En, b1.Rd, b1.Wr, b1.Halted, b1.Fetch};
    assign outv[2] = {b2.Addr_sel, b2.X_sel, b2.Y_sel, b2.ALU_FS, b2.PC_En, b2.IR_En,
                      b2.Acc_En, b2.Rd, b2.Wr, b2.Halted, b2.Fetch};
    assign cntv[0] = b0.Inst_Count;
    assign cntv[1] = b1.Inst_Count;
    assign cntv[2] = {12'd0, b2.Inst_Count};

    localparam logic [11:0] FETCH_C = 12'b0_1_0_10_1_1_0_1_0_0_1;
    localparam logic [11:0] HALT_C  = 12'b0_0_0_00_0_0_0_0_0_1_0;
    localparam logic [11:0] RESET_C = 12'b0_0_0_00_0_0_0_0_0_0_1;
    localparam logic [11:0] STA_C   = 12'b1_0_0_00_0_0_0_0_1_0_0;

    typedef struct {
        logic [3:0]  f;
        logic        n;
        logic        z;
        logic [11:0] exp;
    } vec_t;

    vec_t vecs [13];
    int   checks   = 0;
    int   failures = 0;

    bit   m_halt [3];
    bit   m_exec [3];
    int   m_cnt  [3];
    bit   hoi    [3] = '{1'b0, 1'b1, 1'b0};
    int   cmask  [3] = '{32'hFFFF, 32'hFFFF, 32'hF};

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s act=%h exp=%h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #2;
    endtask

    task automatic do_reset();
        nReset = 1'b0;
        #1;
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("reset_out%0d", i), 32'(outv[i]), 32'(RESET_C));
            chk($sformatf("reset_cnt%0d", i), 32'(cntv[i]), 32'd0);
        end
        tick();
        nReset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            m_halt[i] = 1'b0;
            m_exec[i] = 1'b0;
            m_cnt[i]  = 0;
        end
    endtask

    // Reference: outputs derived from the phase the instruction is in and the opcode table.
    function automatic logic [11:0] model_out(input bit halted, input bit in_exec,
                                              input logic [3:0] f, input logic n, input logic z);
        logic addr, ys, pc, acc, rd, wr;
        logic [1:0] fs;
        if (halted)   return HALT_C;
        if (!in_exec) return FETCH_C;
        addr = 1'b0; ys = 1'b0; pc = 1'b0; acc = 1'b0; rd = 1'b0; wr = 1'b0; fs = 2'b00;
        if (f == 4'd0 || f == 4'd2 || f == 4'd3) begin
            addr = 1'b1;
            rd   = 1'b1;
            acc  = 1'b1;
            fs   = (f == 4'd0) ? 2'b00 : (f == 4'd2) ? 2'b01 : 2'b11;
        end
        if (f == 4'd1) begin
            addr = 1'b1;
            wr   = 1'b1;
        end
        if (f >= 4'd4 && f <= 4'd6) begin
            ys = 1'b1;
            pc = (f == 4'd4) || (f == 4'd5 && !n) || (f == 4'd6 && !z);
        end
        return {addr, 1'b0, ys, fs, pc, 1'b0, acc, rd, wr, 1'b0, 1'b0};
    endfunction

    initial begin
        int hc;
        nReset = 1'b0;
        f_r = 4'd0;
        n_r = 1'b0;
        z_r = 1'b0;

        vecs[0]  = '{4'd0, 1'b0, 1'b0, 12'b1_0_0_00_0_0_1_1_0_0_0};
        vecs[1]  = '{4'd0, 1'b1, 1'b1, 12'b1_0_0_00_0_0_1_1_0_0_0};
        vecs[2]  = '{4'd1, 1'b0, 1'b0, 12'b1_0_0_00_0_0_0_0_1_0_0};
        vecs[3]  = '{4'd2, 1'b1, 1'b0, 12'b1_0_0_01_0_0_1_1_0_0_0};
        vecs[4]  = '{4'd3, 1'b0, 1'b1, 12'b1_0_0_11_0_0_1_1_0_0_0};
        vecs[5]  = '{4'd4, 1'b1, 1'b1, 12'b0_0_1_00_1_0_0_0_0_0_0};
        vecs[6]  = '{4'd5, 1'b1, 1'b0, 12'b0_0_1_00_0_0_0_0_0_0_0};
        vecs[7]  = '{4'd5, 1'b0, 1'b1, 12'b0_0_1_00_1_0_0_0_0_0_0};
        vecs[8]  = '{4'd6, 1'b0, 1'b1, 12'b0_0_1_00_0_0_0_0_0_0_0};
        vecs[9]  = '{4'd6, 1'b1, 1'b0, 12'b0_0_1_00_1_0_0_0_0_0_0};
        vecs[10] = '{4'd6, 1'b0, 1'b0, 12'b0_0_1_00_1_0_0_0_0_0_0};
        vecs[11] = '{4'hA, 1'b0, 1'b0, 12'b0_0_0_00_0_0_0_0_0_0_0};
        vecs[12] = '{4'hF, 1'b1, 1'b1, 12'b0_0_0_00_0_0_0_0_0_0_0};

        #3;
        do_reset();

        for (int k = 0; k < 13; k++) begin
            f_r = vecs[k].f;
            n_r = vecs[k].n;
            z_r = vecs[k].z;
            #1;
            chk($sformatf("vec%0d_fetch", k), 32'(outv[0]), 32'(FETCH_C));
            tick();
            chk($sformatf("vec%0d_exec", k), 32'(outv[0]), 32'(vecs[k].exp));
            tick();
            chk($sformatf("vec%0d_cnt", k), 32'(cntv[0]), 32'(k + 1));
        end

        // STP: halt, stay frozen for 10 cycles, then reset recovers.
        do_reset();
        f_r = 4'd7;
        tick();
        chk("stp_exec", 32'(outv[0]), 32'd0);
        tick();
        for (int k = 0; k < 10; k++) begin
            f_r = 4'($urandom_range(0, 15));
            n_r = 1'($urandom);
            z_r = 1'($urandom);
            #1;
            chk($sformatf("halt_out%0d", k), 32'(outv[0]), 32'(HALT_C));
            chk($sformatf("halt_cnt%0d", k), 32'(cntv[0]), 32'd1);
            tick();
        end
        do_reset();
        #1;
        chk("post_halt_fetch", 32'(outv[0]), 32'(FETCH_C));

        // Illegal opcode: NOP on dut0, halt on dut1.
        do_reset();
        f_r = 4'hA;
        tick();
        chk("ill_exec0", 32'(outv[0]), 32'd0);
        chk("ill_exec1", 32'(outv[1]), 32'd0);
        tick();
        chk("ill_next0", 32'(outv[0]), 32'(FETCH_C));
        chk("ill_next1", 32'(outv[1]), 32'(HALT_C));
        chk("ill_cnt0", 32'(cntv[0]), 32'd1);
        chk("ill_cnt1", 32'(cntv[1]), 32'd1);

        // Reset asserted mid-STA between clock edges.
        do_reset();
        f_r = 4'd1;
        tick();
        chk("sta_exec", 32'(outv[0]), 32'(STA_C));
        #2;
        nReset = 1'b0;
        #1;
        chk("sta_async_wr", 32'(outv[0][2]), 32'd0);
        chk("sta_async_out", 32'(outv[0]), 32'(RESET_C));
        chk("sta_async_cnt", 32'(cntv[0]), 32'd0);
        tick();
        nReset = 1'b1;

        // Counter wrap on the 4-bit instance.
        do_reset();
        f_r = 4'd0;
        repeat (34) tick();
        chk("wrap_cnt2", 32'(cntv[2]), 32'd1);
        chk("wrap_cnt0", 32'(cntv[0]), 32'd17);

        // Random run against the reference model on all three instances.
        do_reset();
        hc = 0;
        for (int c = 0; c < 400; c++) begin
            f_r = ($urandom_range(0, 15) == 0) ? 4'd7 : 4'($urandom_range(0, 15));
            n_r = 1'($urandom);
            z_r = 1'($urandom);
            #1;
            for (int i = 0; i < 3; i++) begin
                chk($sformatf("rnd%0d_out%0d", c, i), 32'(outv[i]),
                    32'(model_out(m_halt[i], m_exec[i], f_r, n_r, z_r)));
                chk($sformatf("rnd%0d_cnt%0d", c, i), 32'(cntv[i]), 32'(m_cnt[i] & cmask[i]));
            end
            @(posedge Clk);
            for (int i = 0; i < 3; i++) begin
                if (!m_halt[i]) begin
                    if (m_exec[i]) begin
                        m_cnt[i]++;
                        m_exec[i] = 1'b0;
                        if (f_r == 4'd7 || (f_r >= 4'd8 && hoi[i])) m_halt[i] = 1'b1;
                    end else begin
                        m_exec[i] = 1'b1;
                    end
                end
            end
            #2;
            if (m_halt[0] || m_halt[1] || m_halt[2]) hc++;
            if (hc >= 4) begin
                do_reset();
                hc = 0;
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
